qspi_flash_sequencer: RTL

Transaction sequencer that sits above the quad-SPI byte engine and drives it one byte at a time. It turns a single flash command request into a framed transaction: chip select assert, CMD byte, optional 24-bit address, optional dummy bytes, optional N data bytes (read or write), then chip select deassert. It owns CS framing and the engine start/done handshake, so host logic only issues commands and streams data.

---
 rtl/qspi_flash_sequencer_pkg.sv | 28 ++
 rtl/qspi_flash_sequencer_if.sv | 37 +++
 rtl/qspi_byte_counter.sv | 34 +++
 rtl/qspi_flash_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/qspi_flash_sequencer_pkg.sv
// Shared types and constants for the quad-SPI flash transaction sequencer.
package qspi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_CS_HOLD,
        ST_DONE
    } state_e;

    localparam int unsigned ADDR_BYTES = 3;
    localparam logic [7:0]  DUMMY_BYTE = 8'h00;

    localparam logic [7:0] WREN  = 8'h06;
    localparam logic [7:0] READ  = 8'h03;
    localparam logic [7:0] QREAD = 8'h6B;
    localparam logic [7:0] PP    = 8'h02;
    localparam logic [7:0] RDSR  = 8'h05;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/qspi_flash_sequencer_if.sv
// Host request/response and byte-engine handshake bundle for the flash sequencer.
interface qspi_flash_sequencer_if #(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned DUMMY_W = 4
);
    logic               req;
    logic [7:0]         cmd;
    logic [23:0]        addr;
    logic               has_addr;
    logic [DUMMY_W-1:0] dummy;
    logic               has_data;
    logic               is_write;
    logic [LEN_W-1:0]   len;
    logic               busy;
    logic               done;
    logic [7:0]         wr_data;
    logic               wr_ready;
    logic [7:0]         rd_data;
    logic               rd_valid;
    logic               eng_start;
    logic [7:0]         eng_tx;
    logic               eng_done;
    logic [7:0]         eng_rx;
    logic               CS;

    modport slave (
        input  req, cmd, addr, has_addr, dummy, has_data, is_write, len,
        input  wr_data, eng_done, eng_rx,
        output busy, done, wr_ready, rd_data, rd_valid, eng_start, eng_tx, CS
    );

    modport master (
        output req, cmd, addr, has_addr, dummy, has_data, is_write, len,
        output wr_data, eng_done, eng_rx,
        input  busy, done, wr_ready, rd_data, rd_valid, eng_start, eng_tx, CS
    );
endinterface

// File: rtl/qspi_byte_counter.sv
// Loadable byte down-counter with zero flag, shared by the ADDR, DUMMY and DATA phases.
module qspi_byte_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);
endmodule

// File: rtl/qspi_flash_sequencer.sv
// Frames one flash command (CMD, ADDR, DUMMY, DATA) under chip select, driving the
// byte engine one byte at a time through its start/done handshake.
module qspi_flash_sequencer
    import qspi_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned DUMMY_W = 4
) (
    input logic                   clk,
    input logic                   reset,
    qspi_flash_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = max_u(max_u(LEN_W, DUMMY_W), 2);

    state_e             state_q, state_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [23:0]        addr_q, addr_d;
    logic               has_addr_q, has_addr_d;
    logic [DUMMY_W-1:0] dummy_q, dummy_d;
    logic               has_data_q, has_data_d;
    logic               is_write_q, is_write_d;
    logic [LEN_W-1:0]   len_q, len_d;

    logic               eng_start_q, eng_start_d;
    logic [7:0]         eng_tx_q, eng_tx_d;
    logic               wr_ready_q, wr_ready_d;
    logic               rd_valid_q, rd_valid_d;
    logic [7:0]         rd_data_q, rd_data_d;

    logic               cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]   cnt_load_val, cnt_val;

    logic               byte_done, enter;
    logic [7:0]         eng_tx_out;
    state_e             enter_st, after_cmd, after_addr, after_dummy;

    qspi_byte_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    // A done arriving in the same cycle as our start cannot belong to that byte.
    assign byte_done   = bus.eng_done && !eng_start_q;
    assign after_dummy = has_data_q ? ST_DATA : ST_CS_HOLD;
    assign after_addr  = (dummy_q != '0) ? ST_DUMMY : after_dummy;
    assign after_cmd   = has_addr_q ? ST_ADDR : after_addr;
    // Write bytes pass straight through in the wr_ready cycle, then are held from eng_tx_q.
    assign eng_tx_out  = wr_ready_q ? bus.wr_data : eng_tx_q;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        has_addr_d   = has_addr_q;
        dummy_d      = dummy_q;
        has_data_d   = has_data_q;
        is_write_d   = is_write_q;
        len_d        = len_q;
        eng_start_d  = 1'b0;
        wr_ready_d   = 1'b0;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        eng_tx_d     = eng_tx_out;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        enter        = 1'b0;
        enter_st     = ST_CS_HOLD;

        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    cmd_d      = bus.cmd;
                    addr_d     = bus.addr;
                    has_addr_d = bus.has_addr;
                    dummy_d    = bus.dummy;
                    has_data_d = bus.has_data;
                    is_write_d = bus.is_write;
                    len_d      = bus.len;
                    state_d    = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                state_d     = ST_CMD;
                eng_start_d = 1'b1;
                eng_tx_d    = cmd_q;
            end
            ST_CMD: begin
                if (byte_done) begin
                    enter    = 1'b1;
                    enter_st = after_cmd;
                end
            end
            ST_ADDR: begin
                if (byte_done) begin
                    if (cnt_zero) begin
                        enter    = 1'b1;
                        enter_st = after_addr;
                    end else begin
                        cnt_dec     = 1'b1;
                        eng_start_d = 1'b1;
                        eng_tx_d    = (cnt_val == CNT_W'(2)) ? addr_q[15:8] : addr_q[7:0];
                    end
                end
            end
            ST_DUMMY: begin
                if (byte_done) begin
                    if (cnt_zero) begin
                        enter    = 1'b1;
                        enter_st = after_dummy;
                    end else begin
                        cnt_dec     = 1'b1;
                        eng_start_d = 1'b1;
                        eng_tx_d    = DUMMY_BYTE;
                    end
                end
            end
            ST_DATA: begin
                if (byte_done) begin
                    if (!is_write_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = bus.eng_rx;
                    end
                    if (cnt_zero) begin
                        enter    = 1'b1;
                        enter_st = ST_CS_HOLD;
                    end else begin
                        cnt_dec     = 1'b1;
                        eng_start_d = 1'b1;
                        wr_ready_d  = is_write_q;
                        eng_tx_d    = DUMMY_BYTE;
                    end
                end
            end
            ST_CS_HOLD: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Entering a byte phase loads its count and starts its first byte immediately.
        if (enter) begin
            state_d = enter_st;
            case (enter_st)
                ST_ADDR: begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(ADDR_BYTES - 1);
                    eng_start_d  = 1'b1;
                    eng_tx_d     = addr_q[23:16];
                end
                ST_DUMMY: begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(dummy_q - DUMMY_W'(1));
                    eng_start_d  = 1'b1;
                    eng_tx_d     = DUMMY_BYTE;
                end
                ST_DATA: begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(len_q);
                    eng_start_d  = 1'b1;
                    wr_ready_d   = is_write_q;
                    eng_tx_d     = DUMMY_BYTE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            has_addr_q  <= 1'b0;
            dummy_q     <= '0;
            has_data_q  <= 1'b0;
            is_write_q  <= 1'b0;
            len_q       <= '0;
            eng_start_q <= 1'b0;
            eng_tx_q    <= '0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            has_addr_q  <= has_addr_d;
            dummy_q     <= dummy_d;
            has_data_q  <= has_data_d;
            is_write_q  <= is_write_d;
            len_q       <= len_d;
            eng_start_q <= eng_start_d;
            eng_tx_q    <= eng_tx_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.CS        = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign bus.eng_start = eng_start_q;
    assign bus.eng_tx    = eng_tx_out;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
endmodule
